truth_table_checker: RTL

//  Response-side counterpart to the 3-input vector driver: samples a 3-input DUT's inputs and

---
 rtl/truth_table_checker_pkg.sv | 20 ++
 rtl/truth_table_checker_sat_counter.sv | 34 +++
 rtl/truth_table_checker.sv | 109 ++++++++++
 3 files changed

// File: rtl/truth_table_checker_pkg.sv
// Shared types and constants for the 3-input truth-table response checker.
package truth_table_checker_pkg;

    localparam int IDX_W   = 3;
    localparam int NUM_VEC = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [NUM_VEC-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_VEC-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/truth_table_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/truth_table_checker.sv
// Samples a 3-input circuit's inputs and output on each valid strobe and scores y against
// an expected truth table: pass/fail counts, input coverage and first-failure capture.
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter logic [NUM_VEC-1:0] TT_EXPECT = 8'b1110_1000,
    parameter int                 CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               vld,
    input  logic               a,
    input  logic               b,
    input  logic               c,
    input  logic               y,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic [NUM_VEC-1:0] covered,
    output logic               first_fail_vld,
    output logic [IDX_W-1:0]   first_fail_idx,
    output logic               busy,
    output logic               done,
    output logic               all_pass,
    output state_t             dbg_state
);

    // Handshake: a sample is taken on any rising edge where vld=1 in RUN and start=0;
    // there is no backpressure, the checker is always ready.
    state_t               state_q, state_d;
    logic [NUM_VEC-1:0]   covered_q, covered_d;
    logic                 ff_vld_q, ff_vld_d;
    logic [IDX_W-1:0]     ff_idx_q, ff_idx_d;
    logic [IDX_W-1:0]     idx;
    logic                 pass_inc;
    logic                 fail_inc;

    assign idx = {a, b, c};

    always_comb begin
        state_d   = state_q;
        covered_d = covered_q;
        ff_vld_d  = ff_vld_q;
        ff_idx_d  = ff_idx_q;
        pass_inc  = 1'b0;
        fail_inc  = 1'b0;
        if (start) begin
            // start always (re)opens a run and drops any coincident sample
            state_d   = RUN;
            covered_d = '0;
            ff_vld_d  = 1'b0;
            ff_idx_d  = '0;
        end else if ((state_q == RUN) && vld) begin
            covered_d = covered_q | idx_onehot(idx);
            // an unknown y makes the equality non-true, so it lands in the fail path
            if (y == TT_EXPECT[idx]) begin
                pass_inc = 1'b1;
            end else begin
                fail_inc = 1'b1;
                if (!ff_vld_q) begin
                    ff_vld_d = 1'b1;
                    ff_idx_d = idx;
                end
            end
            if (covered_d == '1) begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            covered_q <= '0;
            ff_vld_q  <= 1'b0;
            ff_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            covered_q <= covered_d;
            ff_vld_q  <= ff_vld_d;
            ff_idx_q  <= ff_idx_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (start),
        .inc_i (pass_inc),
        .q_o   (pass_cnt)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (start),
        .inc_i (fail_inc),
        .q_o   (fail_cnt)
    );

    assign covered        = covered_q;
    assign first_fail_vld = ff_vld_q;
    assign first_fail_idx = ff_idx_q;
    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign all_pass       = done && (fail_cnt == '0);
    assign dbg_state      = state_q;

endmodule
